// File: rtl/neuron_ctrl_pkg.sv
// Shared types and constants for the neuron status-memory update sequencer.
package neuron_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_BIAS,
    RD_POT,
    RD_TH,
    ACCUM,
    DRAIN,
    FIRE,
    DONE
  } state_t;

  localparam logic [1:0] SEL_BIAS = 2'b00;
  localparam logic [1:0] SEL_POT  = 2'b01;
  localparam logic [1:0] SEL_TH   = 2'b10;
  localparam logic [1:0] SEL_HIST = 2'b11;

  // One guard bit is enough to detect overflow of a two-operand signed add.
  function automatic int sat_sum_width(input int dsize);
    return dsize + 1;
  endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational signed add clamped to the DSIZE-bit two's complement range.
module sat_add
  import neuron_ctrl_pkg::*;
#(
  parameter int DSIZE = 16
) (
  input  logic signed [DSIZE-1:0] a,
  input  logic signed [DSIZE-1:0] b,
  output logic signed [DSIZE-1:0] sum
);

  localparam int SW = sat_sum_width(DSIZE);
  localparam logic signed [DSIZE-1:0] MAX_VAL = {1'b0, {(DSIZE-1){1'b1}}};
  localparam logic signed [DSIZE-1:0] MIN_VAL = {1'b1, {(DSIZE-1){1'b0}}};

  logic signed [SW-1:0] wide;

  assign wide = $signed({a[DSIZE-1], a}) + $signed({b[DSIZE-1], b});

  // Overflow shows as disagreement between the guard bit and the result sign.
  always_comb begin
    if (wide[SW-1] != wide[SW-2]) begin
      sum = wide[SW-1] ? MIN_VAL : MAX_VAL;
    end else begin
      sum = wide[DSIZE-1:0];
    end
  end

endmodule

// File: rtl/neuron_update_ctrl.sv
// Per-timestep sweep over all neurons: read bias/pot/th, integrate spiking-axon
// weights with saturation, threshold, write back membrane potential, emit spikes.
module neuron_update_ctrl
  import neuron_ctrl_pkg::*;
#(
  parameter int NUM_NURNS          = 256,
  parameter int NUM_AXONS          = 256,
  parameter int DSIZE              = 16,
  parameter int NURN_CNT_BIT_WIDTH = 8,
  parameter int AXON_CNT_BIT_WIDTH = 8
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         start_i,
  input  logic [NUM_AXONS-1:0]                         axonSpikes_i,
  output logic                                         busy_o,
  output logic                                         done_o,
  output logic                                         spike_o,
  output logic [NURN_CNT_BIT_WIDTH-1:0]                spikeId_o,
  output logic [NURN_CNT_BIT_WIDTH+1:0]                Addr_StatRd_A_o,
  output logic                                         rdEn_StatRd_A_o,
  input  logic [DSIZE-1:0]                             data_StatRd_A_i,
  output logic [NURN_CNT_BIT_WIDTH+1:0]                Addr_StatWr_B_o,
  output logic                                         wrEn_StatWr_B_o,
  output logic [DSIZE-1:0]                             data_StatWr_B_o,
  output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] Addr_StatRd_E_o,
  output logic                                         rdEn_StatRd_E_o,
  input  logic [DSIZE-1:0]                             data_StatRd_E_i
);

  localparam logic [NURN_CNT_BIT_WIDTH-1:0] N_LAST = NURN_CNT_BIT_WIDTH'(NUM_NURNS - 1);
  localparam logic [AXON_CNT_BIT_WIDTH-1:0] A_LAST = AXON_CNT_BIT_WIDTH'(NUM_AXONS - 1);

  state_t                          state;
  state_t                          next;
  logic [NUM_AXONS-1:0]            spikes;
  logic [NURN_CNT_BIT_WIDTH-1:0]   n;
  logic [AXON_CNT_BIT_WIDTH-1:0]   a;
  logic signed [DSIZE-1:0]         bias;
  logic signed [DSIZE-1:0]         acc;
  logic signed [DSIZE-1:0]         th;
  logic                            pend;
  logic signed [DSIZE-1:0]         add_a;
  logic signed [DSIZE-1:0]         add_b;
  logic signed [DSIZE-1:0]         add_sum;
  logic                            fire;

  // One adder serves both the pot+bias step and every weight accumulation.
  assign add_a = (state == RD_TH) ? $signed(data_StatRd_A_i) : acc;
  assign add_b = (state == RD_TH) ? bias : $signed(data_StatRd_E_i);

  sat_add #(.DSIZE(DSIZE)) u_sat_add (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  assign fire = (acc >= th);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      spikes <= '0;
      n      <= '0;
      a      <= '0;
      bias   <= '0;
      acc    <= '0;
      th     <= '0;
      pend   <= 1'b0;
    end else begin
      state <= next;
      case (state)
        IDLE: begin
          if (start_i) begin
            spikes <= axonSpikes_i;
            n      <= '0;
          end
        end
        RD_POT: bias <= $signed(data_StatRd_A_i);
        RD_TH: begin
          acc  <= add_sum;
          pend <= 1'b0;
          a    <= '0;
        end
        ACCUM: begin
          if (a == '0) th <= $signed(data_StatRd_A_i);
          if (pend) acc <= add_sum;
          pend <= spikes[a];
          a    <= (a == A_LAST) ? '0 : a + 1'b1;
        end
        DRAIN: begin
          if (pend) acc <= add_sum;
          pend <= 1'b0;
        end
        FIRE: begin
          if (n != N_LAST) n <= n + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next            = state;
    busy_o          = 1'b0;
    done_o          = 1'b0;
    spike_o         = 1'b0;
    spikeId_o       = '0;
    Addr_StatRd_A_o = '0;
    rdEn_StatRd_A_o = 1'b0;
    Addr_StatWr_B_o = '0;
    wrEn_StatWr_B_o = 1'b0;
    data_StatWr_B_o = '0;
    Addr_StatRd_E_o = '0;
    rdEn_StatRd_E_o = 1'b0;

    case (state)
      IDLE: begin
        if (start_i) next = RD_BIAS;
      end
      RD_BIAS: begin
        busy_o          = 1'b1;
        rdEn_StatRd_A_o = 1'b1;
        Addr_StatRd_A_o = {n, SEL_BIAS};
        next            = RD_POT;
      end
      RD_POT: begin
        busy_o          = 1'b1;
        rdEn_StatRd_A_o = 1'b1;
        Addr_StatRd_A_o = {n, SEL_POT};
        next            = RD_TH;
      end
      RD_TH: begin
        busy_o          = 1'b1;
        rdEn_StatRd_A_o = 1'b1;
        Addr_StatRd_A_o = {n, SEL_TH};
        next            = ACCUM;
      end
      ACCUM: begin
        busy_o = 1'b1;
        if (spikes[a]) begin
          rdEn_StatRd_E_o = 1'b1;
          Addr_StatRd_E_o = {n, a};
        end
        if (a == A_LAST) next = DRAIN;
      end
      DRAIN: begin
        busy_o = 1'b1;
        next   = FIRE;
      end
      FIRE: begin
        busy_o          = 1'b1;
        wrEn_StatWr_B_o = 1'b1;
        Addr_StatWr_B_o = {n, SEL_POT};
        data_StatWr_B_o = fire ? '0 : acc;
        spike_o         = fire;
        spikeId_o       = fire ? n : '0;
        next            = (n == N_LAST) ? DONE : RD_BIAS;
      end
      DONE: begin
        done_o = 1'b1;
        next   = IDLE;
      end
      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_neuron_update_ctrl.sv
// Scoreboard bench: stimulus queues expected port events, a negedge monitor checks them.
module tb_neuron_update_ctrl;

  localparam int NN = 4;
  localparam int NA = 4;
  localparam int NB = 2;
  localparam int AB = 2;
  localparam int DS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start;
  logic [NA-1:0]     spikes;
  logic              busy, done, spike;
  logic [NB-1:0]     spike_id;
  logic [NB+1:0]     addr_a;
  logic              rden_a;
  logic [DS-1:0]     data_a;
  logic [NB+1:0]     addr_b;
  logic              wren_b;
  logic [DS-1:0]     data_b;
  logic [NB+AB-1:0]  addr_e;
  logic              rden_e;
  logic [DS-1:0]     data_e;

  neuron_update_ctrl #(
    .NUM_NURNS(NN), .NUM_AXONS(NA), .DSIZE(DS),
    .NURN_CNT_BIT_WIDTH(NB), .AXON_CNT_BIT_WIDTH(AB)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .axonSpikes_i(spikes),
    .busy_o(busy), .done_o(done), .spike_o(spike), .spikeId_o(spike_id),
    .Addr_StatRd_A_o(addr_a), .rdEn_StatRd_A_o(rden_a), .data_StatRd_A_i(data_a),
    .Addr_StatWr_B_o(addr_b), .wrEn_StatWr_B_o(wren_b), .data_StatWr_B_o(data_b),
    .Addr_StatRd_E_o(addr_e), .rdEn_StatRd_E_o(rden_e), .data_StatRd_E_i(data_e)
  );

  // Status and weight memories with one-cycle registered reads.
  logic [DS-1:0] stat_mem   [16];
  logic [DS-1:0] weight_mem [16];
  initial begin
    data_a = '0;
    data_e = '0;
  end
  always @(posedge clk) begin
    if (rden_a) data_a <= stat_mem[addr_a];
    if (rden_e) data_e <= weight_mem[addr_e];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;   // 0 weight read, 1 potential write, 2 done
    logic [15:0] adr;
    logic [15:0] dat;
    logic        sp;
    logic [1:0]  id;
    int          c;
  } ev_t;

  ev_t q[$];
  int  tests = 0;
  int  fails = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void push_e(input logic [1:0] nn, input logic [1:0] aa);
    ev_t e;
    e = '{kind: 0, adr: 16'({nn, aa}), dat: 16'h0, sp: 1'b0, id: 2'd0, c: 0};
    q.push_back(e);
  endfunction

  function automatic void push_neuron(input logic [1:0] nn, input logic [3:0] sp,
                                      input logic [15:0] d, input logic f);
    ev_t e;
    for (int i = 0; i < NA; i++) if (sp[i]) push_e(nn, 2'(i));
    e = '{kind: 1, adr: 16'({nn, 2'b01}), dat: d, sp: f, id: nn, c: 0};
    q.push_back(e);
  endfunction

  function automatic void push_done(input int c);
    ev_t e;
    e = '{kind: 2, adr: 16'h0, dat: 16'h0, sp: 1'b0, id: 2'd0, c: c};
    q.push_back(e);
  endfunction

  // Expected writes for the memory image after th(n0)=20 and th(n3)=0.
  function automatic void push_sweep_b(input int s);
    push_neuron(2'd0, 4'b0101, 16'h0000, 1'b1);
    push_neuron(2'd1, 4'b0101, 16'h0000, 1'b1);
    push_neuron(2'd2, 4'b0101, 16'h8000, 1'b0);
    push_neuron(2'd3, 4'b0101, 16'h0000, 1'b1);
    push_done(s + 37);
  endfunction

  function automatic void push_sweep_quiet(input int s);
    push_neuron(2'd0, 4'b0000, 16'd11,   1'b0);
    push_neuron(2'd1, 4'b0000, 16'h7FF0, 1'b0);
    push_neuron(2'd2, 4'b0000, 16'h8000, 1'b0);
    push_neuron(2'd3, 4'b0000, 16'h0000, 1'b1);
    push_done(s + 37);
  endfunction

  always @(negedge clk) begin
    ev_t e;
    int  k;
    if (rden_e || wren_b || spike || done) begin
      k = done ? 2 : ((wren_b || spike) ? 1 : 0);
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: kind %0d at cycle %0d, expected nothing", k, cyc);
      end else begin
        e = q.pop_front();
        check("event_kind", 64'(k), 64'(e.kind));
        if (k == e.kind) begin
          case (k)
            0: check("e_addr", 64'(addr_e), 64'(e.adr));
            1: begin
              check("b_addr", 64'(addr_b), 64'(e.adr));
              check("b_data", 64'(data_b), 64'(e.dat));
              check("b_en_spike", 64'({wren_b, rden_a, spike, spike ? spike_id : 2'b00}),
                    64'({1'b1, 1'b0, e.sp, e.sp ? e.id : 2'b00}));
            end
            default: begin
              check("done_cycle", 64'(cyc), 64'(e.c));
              check("done_busy", 64'(busy), 64'd0);
            end
          endcase
        end
      end
    end
  end

  function automatic logic [63:0] all_outs();
    return 64'({busy, done, spike, spike_id, addr_a, rden_a, addr_b, wren_b, data_b, addr_e, rden_e});
  endfunction

  task automatic start_sweep(input logic [3:0] sp, output int s);
    @(negedge clk);
    start  = 1'b1;
    spikes = sp;
    s      = cyc;
    @(negedge clk);
    start  = 1'b0;
    spikes = '0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(name, 64'(q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s2;
    rst    = 1'b1;
    start  = 1'b0;
    spikes = '0;
    for (int i = 0; i < 16; i++) begin
      stat_mem[i]   = '0;
      weight_mem[i] = '0;
    end
    stat_mem[0] = 16'd1;    stat_mem[1] = 16'd10;   stat_mem[2]  = 16'd100;
    stat_mem[5] = 16'h7FF0; stat_mem[6] = 16'h7FFF;
    stat_mem[8] = 16'hFF00; stat_mem[9] = 16'h8010; stat_mem[10] = 16'h7FFF;
    stat_mem[14] = 16'h7FFF;
    weight_mem[0] = 16'd5; weight_mem[1] = 16'd6; weight_mem[2] = 16'd7; weight_mem[3] = 16'd8;
    weight_mem[4] = 16'h0100;

    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;

    // Sparse spikes, no fire, positive and negative saturation.
    start_sweep(4'b0101, s);
    push_neuron(2'd0, 4'b0101, 16'd23,   1'b0);
    push_neuron(2'd1, 4'b0101, 16'h0000, 1'b1);
    push_neuron(2'd2, 4'b0101, 16'h8000, 1'b0);
    push_neuron(2'd3, 4'b0101, 16'h0000, 1'b0);
    push_done(s + 37);
    drain("sweep_basic_drained");

    // Lower thresholds: n0 fires, n3 fires on equality.
    stat_mem[2]  = 16'd20;
    stat_mem[14] = 16'h0000;
    start_sweep(4'b0101, s);
    push_sweep_b(s);
    drain("sweep_fire_drained");

    // No spikes, ignored mid-sweep start, then start during done then in idle.
    start_sweep(4'b0000, s);
    check("busy_after_start", 64'(busy), 64'd1);
    push_sweep_quiet(s);
    repeat (9) @(negedge clk);
    start  = 1'b1;
    spikes = 4'b1111;
    @(negedge clk);
    start  = 1'b0;
    spikes = '0;
    repeat (26) @(negedge clk);
    start  = 1'b1;
    spikes = 4'b0101;
    @(negedge clk);
    check("busy_idle_after_done", 64'(busy), 64'd0);
    s2 = cyc;
    @(negedge clk);
    start  = 1'b0;
    spikes = '0;
    check("busy_back_to_back", 64'(busy), 64'd1);
    push_sweep_b(s2);
    drain("sweep_b2b_drained");

    // Reset during neuron 2 accumulation abandons the sweep.
    start_sweep(4'b0000, s);
    push_neuron(2'd0, 4'b0000, 16'd11,   1'b0);
    push_neuron(2'd1, 4'b0000, 16'h7FF0, 1'b0);
    repeat (22) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midsweep_reset_outputs", all_outs(), 64'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_no_pending", 64'(q.size()), 64'd0);

    start_sweep(4'b0000, s);
    push_sweep_quiet(s);
    drain("sweep_after_reset_drained");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
